// File: rtl/if_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared constants for the instruction-fetch queue: default reset PC, the
// zero/NOP instruction word, boolean levels and the fetch FSM state encodings.
// No ports.
// -----------------------------------------------------------------------------
package if_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Fetch FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/if_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_if
// Bundles the fetch front-end signals: redirect from EX, the request/response
// channel to instruction memory and the valid/ready handshake toward ID.
//   master : the fetch queue itself
//   slave  : the environment (EX redirect, instruction memory, ID stage)
// -----------------------------------------------------------------------------
interface if_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [INST_W-1:0] resp_inst;
    logic [ADDR_W-1:0] resp_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;
    logic              id_ready;
    logic              if_stall;

    modport master (
        input  flush, flush_pc, req_ready, resp_valid, resp_inst, resp_pc, id_ready,
        output req_valid, req_addr, inst_valid, inst_o, pc_o, if_stall
    );

    modport slave (
        output flush, flush_pc, req_ready, resp_valid, resp_inst, resp_pc, id_ready,
        input  req_valid, req_addr, inst_valid, inst_o, pc_o, if_stall
    );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_fifo
// DEPTH-entry circular buffer holding {instruction, pc} words for the fetch
// queue. Clear wins over push/pop in the same cycle. The head word is raw
// storage; the caller masks it when the buffer is empty.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: write one entry at the tail
//   i_pop          : retire the head entry
//   i_clear        : drop all entries
//   o_head         : entry at the head pointer
//   o_count        : number of valid entries (0..DEPTH)
//   o_empty        : o_count == 0
// -----------------------------------------------------------------------------
module if_fetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; entries are only visible through the count
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) r_mem[r_tail] <= i_wdata;
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// Sequential instruction prefetcher with a DEPTH-entry queue toward ID.
// Owns the fetch PC, keeps at most one request outstanding to instruction
// memory and only accepts a response whose PC matches the pending request.
// A flush empties the queue, retargets the fetch PC and discards the
// in-flight response, if any.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (master)   : flush/flush_pc, req_*, resp_*, inst_valid/inst_o/pc_o,
//                    id_ready, if_stall
//   o_count        : current queue occupancy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; request issued when a slot is free
// WAIT  | one request outstanding; waiting for the matching response
// DROP  | one stale request outstanding; its response is discarded
// -----------------------------------------------------------------------------
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    if_fetch_queue_if.master       bus,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INST_W + ADDR_W;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pending_pc;

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] w_pending_pc_nxt;

    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic [ENT_W-1:0]  w_head;
    logic              w_inflight;
    logic [CNT_W:0]    w_used;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_resp_hit;
    logic              w_inst_valid;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_flush_pc;
    logic              w_unused;

    if_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .i_wdata ({bus.resp_inst, bus.resp_pc}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // A slot is reserved for the outstanding request, so a returning
    // instruction can always be pushed.
    assign w_inflight = (r_state != ST_IDLE);
    assign w_used     = {1'b0, w_count} + {{CNT_W{1'b0}}, w_inflight};
    assign w_credit   = (w_used < (CNT_W+1)'(DEPTH));

    // Gated by reset so req_valid reads 0 while reset is held
    assign w_req_valid  = i_rst_n && (r_state == ST_IDLE) && w_credit;
    assign w_req_fire   = w_req_valid && bus.req_ready;
    assign w_resp_hit   = (r_state == ST_WAIT) && bus.resp_valid &&
                          (bus.resp_pc == r_pending_pc);
    assign w_inst_valid = !w_empty;
    assign w_push       = w_resp_hit && !bus.flush;
    assign w_pop        = w_inst_valid && bus.id_ready && !bus.flush;
    assign w_flush_pc   = {bus.flush_pc[ADDR_W-1:2], 2'b00};
    assign w_unused     = ^bus.flush_pc[1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_pending_pc_nxt = r_pending_pc;
        if (bus.flush) begin
            w_fetch_pc_nxt = w_flush_pc;
            case (r_state)
                // A request accepted in the flush cycle is already stale
                ST_IDLE: if (w_req_fire) w_state_nxt = ST_DROP;
                // If the pending response lands in the flush cycle it is
                // consumed (and dropped) right here; nothing is left to
                // discard, and waiting in DROP would never end.
                ST_WAIT: w_state_nxt = w_resp_hit ? ST_IDLE : ST_DROP;
                // Same reasoning: the single stale response may arrive now
                ST_DROP: w_state_nxt = bus.resp_valid ? ST_IDLE : ST_DROP;
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        w_pending_pc_nxt = r_fetch_pc;
                        w_fetch_pc_nxt   = r_fetch_pc + ADDR_W'(4);
                        w_state_nxt      = ST_WAIT;
                    end
                end
                ST_WAIT: if (w_resp_hit)     w_state_nxt = ST_IDLE;
                ST_DROP: if (bus.resp_valid) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_pending_pc <= w_pending_pc_nxt;
        end
    end

    assign bus.req_valid  = w_req_valid;
    assign bus.req_addr   = r_fetch_pc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst_o     = w_inst_valid ? w_head[ENT_W-1:ADDR_W] : INST_W'(NOP_INST);
    assign bus.pc_o       = w_inst_valid ? w_head[ADDR_W-1:0]     : '0;
    assign bus.if_stall   = w_inst_valid ? FALSE : TRUE;
    assign o_count        = w_count;
endmodule
